// File: rtl/tlrot_tl_arbiter.sv
// Two-host TL-UL arbiter in front of the RoT register port: round-robin A-channel grant
// with a hold-until-accepted lock, and in-order D-channel steering via a small order FIFO.
module tlrot_tl_arbiter #(
  parameter int MaxOutstanding = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        h0_a_valid,
  output logic        h0_a_ready,
  input  logic [2:0]  h0_a_bits_opcode,
  input  logic [2:0]  h0_a_bits_param,
  input  logic [1:0]  h0_a_bits_size,
  input  logic [7:0]  h0_a_bits_source,
  input  logic [31:0] h0_a_bits_address,
  input  logic [3:0]  h0_a_bits_mask,
  input  logic [31:0] h0_a_bits_data,
  output logic        h0_d_valid,
  input  logic        h0_d_ready,
  output logic [2:0]  h0_d_bits_opcode,
  output logic [2:0]  h0_d_bits_param,
  output logic [1:0]  h0_d_bits_size,
  output logic [7:0]  h0_d_bits_source,
  output logic        h0_d_bits_sink,
  output logic [31:0] h0_d_bits_data,
  output logic        h0_d_bits_denied,

  input  logic        h1_a_valid,
  output logic        h1_a_ready,
  input  logic [2:0]  h1_a_bits_opcode,
  input  logic [2:0]  h1_a_bits_param,
  input  logic [1:0]  h1_a_bits_size,
  input  logic [7:0]  h1_a_bits_source,
  input  logic [31:0] h1_a_bits_address,
  input  logic [3:0]  h1_a_bits_mask,
  input  logic [31:0] h1_a_bits_data,
  output logic        h1_d_valid,
  input  logic        h1_d_ready,
  output logic [2:0]  h1_d_bits_opcode,
  output logic [2:0]  h1_d_bits_param,
  output logic [1:0]  h1_d_bits_size,
  output logic [7:0]  h1_d_bits_source,
  output logic        h1_d_bits_sink,
  output logic [31:0] h1_d_bits_data,
  output logic        h1_d_bits_denied,

  output logic        dev_a_valid,
  input  logic        dev_a_ready,
  output logic [2:0]  dev_a_bits_opcode,
  output logic [2:0]  dev_a_bits_param,
  output logic [1:0]  dev_a_bits_size,
  output logic [7:0]  dev_a_bits_source,
  output logic [31:0] dev_a_bits_address,
  output logic [3:0]  dev_a_bits_mask,
  output logic [31:0] dev_a_bits_data,
  input  logic        dev_d_valid,
  output logic        dev_d_ready,
  input  logic [2:0]  dev_d_bits_opcode,
  input  logic [2:0]  dev_d_bits_param,
  input  logic [1:0]  dev_d_bits_size,
  input  logic [7:0]  dev_d_bits_source,
  input  logic        dev_d_bits_sink,
  input  logic [31:0] dev_d_bits_data,
  input  logic        dev_d_bits_denied,

  output logic        busy_o,
  output logic        err_o
);

  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CW-1:0] CntMax  = CW'(MaxOutstanding);
  localparam logic [PW-1:0] PtrLast = PW'(MaxOutstanding - 1);

  logic          prio_reg, lock_reg, lock_id_reg, err_reg;
  logic          prio_next, lock_next, lock_id_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] wptr_reg, wptr_next, rptr_reg, rptr_next;
  logic          order_mem [MaxOutstanding];

  logic [1:0] a_valid_vec, d_ready_vec, a_ready_vec, d_valid_vec;
  logic       grant, head, full, empty, a_fire, d_fire;

  assign a_valid_vec = {h1_a_valid, h0_a_valid};
  assign d_ready_vec = {h1_d_ready, h0_d_ready};
  assign full  = (count_reg == CntMax);
  assign empty = (count_reg == '0);
  assign head  = order_mem[rptr_reg];

  // With nobody requesting the grant rests on prio, so host 0 tracks dev_a_ready out of reset.
  always_comb begin
    grant = prio_reg;
    if (lock_reg)                         grant = lock_id_reg;
    else if (a_valid_vec == 2'b11)        grant = prio_reg;
    else if (a_valid_vec[1])              grant = 1'b1;
    else if (a_valid_vec[0])              grant = 1'b0;
  end

  assign dev_a_valid = a_valid_vec[grant] && !full;
  assign a_fire      = dev_a_valid && dev_a_ready;
  // Stray responses (nothing outstanding) are sunk rather than stalling the RoT.
  assign dev_d_ready = empty ? 1'b1 : d_ready_vec[head];
  assign d_fire      = dev_d_valid && dev_d_ready && !empty;

  for (genvar gi = 0; gi < 2; gi++) begin : g_host
    assign a_ready_vec[gi] = (grant == 1'(gi)) && dev_a_ready && !full;
    assign d_valid_vec[gi] = dev_d_valid && !empty && (head == 1'(gi));
  end

  assign h0_a_ready = a_ready_vec[0];
  assign h1_a_ready = a_ready_vec[1];
  assign h0_d_valid = d_valid_vec[0];
  assign h1_d_valid = d_valid_vec[1];

  assign dev_a_bits_opcode  = grant ? h1_a_bits_opcode  : h0_a_bits_opcode;
  assign dev_a_bits_param   = grant ? h1_a_bits_param   : h0_a_bits_param;
  assign dev_a_bits_size    = grant ? h1_a_bits_size    : h0_a_bits_size;
  assign dev_a_bits_source  = grant ? h1_a_bits_source  : h0_a_bits_source;
  assign dev_a_bits_address = grant ? h1_a_bits_address : h0_a_bits_address;
  assign dev_a_bits_mask    = grant ? h1_a_bits_mask    : h0_a_bits_mask;
  assign dev_a_bits_data    = grant ? h1_a_bits_data    : h0_a_bits_data;

  assign h0_d_bits_opcode = dev_d_bits_opcode;
  assign h0_d_bits_param  = dev_d_bits_param;
  assign h0_d_bits_size   = dev_d_bits_size;
  assign h0_d_bits_source = dev_d_bits_source;
  assign h0_d_bits_sink   = dev_d_bits_sink;
  assign h0_d_bits_data   = dev_d_bits_data;
  assign h0_d_bits_denied = dev_d_bits_denied;
  assign h1_d_bits_opcode = dev_d_bits_opcode;
  assign h1_d_bits_param  = dev_d_bits_param;
  assign h1_d_bits_size   = dev_d_bits_size;
  assign h1_d_bits_source = dev_d_bits_source;
  assign h1_d_bits_sink   = dev_d_bits_sink;
  assign h1_d_bits_data   = dev_d_bits_data;
  assign h1_d_bits_denied = dev_d_bits_denied;

  always_comb begin
    prio_next    = prio_reg;
    lock_next    = lock_reg;
    lock_id_next = lock_id_reg;
    count_next   = count_reg;
    wptr_next    = wptr_reg;
    rptr_next    = rptr_reg;
    if (a_fire) begin
      prio_next = ~grant;
      lock_next = 1'b0;
      wptr_next = (wptr_reg == PtrLast) ? '0 : wptr_reg + 1'b1;
    end else if (dev_a_valid) begin
      lock_next    = 1'b1;
      lock_id_next = grant;
    end
    if (d_fire) rptr_next = (rptr_reg == PtrLast) ? '0 : rptr_reg + 1'b1;
    unique case ({a_fire, d_fire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_reg    <= 1'b0;
      lock_reg    <= 1'b0;
      lock_id_reg <= 1'b0;
      count_reg   <= '0;
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      prio_reg    <= prio_next;
      lock_reg    <= lock_next;
      lock_id_reg <= lock_id_next;
      count_reg   <= count_next;
      wptr_reg    <= wptr_next;
      rptr_reg    <= rptr_next;
      err_reg     <= dev_d_valid && empty;
    end
  end

  // Order entries need no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (a_fire) order_mem[wptr_reg] <= grant;
  end

  assign busy_o = (count_reg != '0);
  assign err_o  = err_reg;

endmodule

// File: tb/tb_tlrot_tl_arbiter.sv
// Randomized bench for tlrot_tl_arbiter against a queue-based model of grant order and routing.
module tb_tlrot_tl_arbiter;

  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic        hv [2];
  logic        hdr [2];
  logic [2:0]  hop [2];
  logic [2:0]  hpar [2];
  logic [1:0]  hsz [2];
  logic [7:0]  hsrc [2];
  logic [31:0] haddr [2];
  logic [3:0]  hmask [2];
  logic [31:0] hdat [2];
  logic        har [2];
  logic        hdv [2];
  logic [2:0]  hd_op [2];
  logic [2:0]  hd_par [2];
  logic [1:0]  hd_sz [2];
  logic [7:0]  hd_src [2];
  logic        hd_sink [2];
  logic [31:0] hd_dat [2];
  logic        hd_den [2];

  logic        dev_a_valid, dev_a_ready;
  logic [2:0]  da_op, da_par;
  logic [1:0]  da_sz;
  logic [7:0]  da_src;
  logic [31:0] da_addr, da_dat;
  logic [3:0]  da_mask;
  logic        dev_d_valid, dev_d_ready;
  logic [2:0]  dd_op, dd_par;
  logic [1:0]  dd_sz;
  logic [7:0]  dd_src;
  logic        dd_sink, dd_den;
  logic [31:0] dd_dat;
  logic        busy_o, err_o;

  tlrot_tl_arbiter #(.MaxOutstanding(MAX_OUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .h0_a_valid(hv[0]), .h0_a_ready(har[0]),
    .h0_a_bits_opcode(hop[0]), .h0_a_bits_param(hpar[0]), .h0_a_bits_size(hsz[0]),
    .h0_a_bits_source(hsrc[0]), .h0_a_bits_address(haddr[0]), .h0_a_bits_mask(hmask[0]),
    .h0_a_bits_data(hdat[0]),
    .h0_d_valid(hdv[0]), .h0_d_ready(hdr[0]),
    .h0_d_bits_opcode(hd_op[0]), .h0_d_bits_param(hd_par[0]), .h0_d_bits_size(hd_sz[0]),
    .h0_d_bits_source(hd_src[0]), .h0_d_bits_sink(hd_sink[0]), .h0_d_bits_data(hd_dat[0]),
    .h0_d_bits_denied(hd_den[0]),
    .h1_a_valid(hv[1]), .h1_a_ready(har[1]),
    .h1_a_bits_opcode(hop[1]), .h1_a_bits_param(hpar[1]), .h1_a_bits_size(hsz[1]),
    .h1_a_bits_source(hsrc[1]), .h1_a_bits_address(haddr[1]), .h1_a_bits_mask(hmask[1]),
    .h1_a_bits_data(hdat[1]),
    .h1_d_valid(hdv[1]), .h1_d_ready(hdr[1]),
    .h1_d_bits_opcode(hd_op[1]), .h1_d_bits_param(hd_par[1]), .h1_d_bits_size(hd_sz[1]),
    .h1_d_bits_source(hd_src[1]), .h1_d_bits_sink(hd_sink[1]), .h1_d_bits_data(hd_dat[1]),
    .h1_d_bits_denied(hd_den[1]),
    .dev_a_valid(dev_a_valid), .dev_a_ready(dev_a_ready),
    .dev_a_bits_opcode(da_op), .dev_a_bits_param(da_par), .dev_a_bits_size(da_sz),
    .dev_a_bits_source(da_src), .dev_a_bits_address(da_addr), .dev_a_bits_mask(da_mask),
    .dev_a_bits_data(da_dat),
    .dev_d_valid(dev_d_valid), .dev_d_ready(dev_d_ready),
    .dev_d_bits_opcode(dd_op), .dev_d_bits_param(dd_par), .dev_d_bits_size(dd_sz),
    .dev_d_bits_source(dd_src), .dev_d_bits_sink(dd_sink), .dev_d_bits_data(dd_dat),
    .dev_d_bits_denied(dd_den),
    .busy_o(busy_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of issuing host ids, preferred host, held grant (-1 = none).
  int q[$];
  int pref = 0;
  int held = -1;
  bit stray_prev = 0;
  bit pend [2];
  int n_afire = 0, n_dfire = 0, n_full = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pref = 0;
    held = -1;
    stray_prev = 0;
    for (int h = 0; h < 2; h++) begin
      pend[h] = 0;
      hv[h]   = 0;
      hdr[h]  = 0;
    end
    dev_d_valid = 0;
  endtask

  task automatic step(input int pv, input int pa, input int pd);
    int g;
    bit full, empty, exp_dav, exp_ddr, afire, dfire;
    @(negedge clk);
    for (int h = 0; h < 2; h++) begin
      if (!pend[h]) begin
        if ($urandom_range(99) < pv) begin
          hv[h] = 1; pend[h] = 1;
          hop[h] = 3'($urandom); hpar[h] = 3'($urandom); hsz[h] = 2'($urandom);
          hsrc[h] = 8'($urandom); haddr[h] = $urandom; hmask[h] = 4'($urandom);
          hdat[h] = $urandom;
        end else begin
          hv[h] = 0;
        end
      end
      hdr[h] = ($urandom_range(99) < 75);
    end
    dev_a_ready = ($urandom_range(99) < pa);
    dev_d_valid = ($urandom_range(99) < pd);
    dd_op = 3'($urandom); dd_par = 3'($urandom); dd_sz = 2'($urandom);
    dd_src = 8'($urandom); dd_sink = 1'($urandom); dd_dat = $urandom; dd_den = 1'($urandom);
    #1;
    full  = (q.size() == MAX_OUT);
    empty = (q.size() == 0);
    if (full) n_full++;
    if (held >= 0)            g = held;
    else if (hv[0] && hv[1])  g = pref;
    else if (hv[1])           g = 1;
    else if (hv[0])           g = 0;
    else                      g = pref;
    exp_dav = hv[g] && !full;
    exp_ddr = empty ? 1'b1 : hdr[q[0]];
    chk("dev_a_valid", 32'(dev_a_valid), 32'(exp_dav));
    chk("h0_a_ready", 32'(har[0]), 32'(g == 0 && dev_a_ready && !full));
    chk("h1_a_ready", 32'(har[1]), 32'(g == 1 && dev_a_ready && !full));
    if (exp_dav) begin
      chk("dev_a_addr", da_addr, haddr[g]);
      chk("dev_a_data", da_dat, hdat[g]);
      chk("dev_a_ctl", {12'd0, da_op, da_par, da_sz, da_src, da_mask},
          {12'd0, hop[g], hpar[g], hsz[g], hsrc[g], hmask[g]});
    end
    chk("dev_d_ready", 32'(dev_d_ready), 32'(exp_ddr));
    chk("h0_d_valid", 32'(hdv[0]), 32'(dev_d_valid && !empty && q[0] == 0));
    chk("h1_d_valid", 32'(hdv[1]), 32'(dev_d_valid && !empty && q[0] == 1));
    if (dev_d_valid && !empty) begin
      chk("d_data", hd_dat[q[0]], dd_dat);
      chk("d_ctl", {20'd0, hd_op[q[0]], hd_par[q[0]], hd_sz[q[0]], hd_src[q[0]],
                    hd_sink[q[0]], hd_den[q[0]]},
          {20'd0, dd_op, dd_par, dd_sz, dd_src, dd_sink, dd_den});
    end
    chk("busy_o", 32'(busy_o), 32'(!empty));
    chk("err_o", 32'(err_o), 32'(stray_prev));
    afire = exp_dav && dev_a_ready;
    dfire = dev_d_valid && exp_ddr && !empty;
    @(posedge clk);
    if (dfire) begin void'(q.pop_front()); n_dfire++; end
    if (afire) begin
      q.push_back(g);
      pend[g] = 0;
      pref = 1 - g;
      held = -1;
      n_afire++;
    end else if (exp_dav) begin
      held = g;
    end
    stray_prev = dev_d_valid && empty;
  endtask

  initial begin
    int guard;
    for (int h = 0; h < 2; h++) begin
      hop[h] = 0; hpar[h] = 0; hsz[h] = 0; hsrc[h] = 0;
      haddr[h] = 0; hmask[h] = 0; hdat[h] = 0;
    end
    dd_op = 0; dd_par = 0; dd_sz = 0; dd_src = 0; dd_sink = 0; dd_dat = 0; dd_den = 0;
    model_reset();
    rst_ni = 0;
    dev_a_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dev_a_valid", 32'(dev_a_valid), 0);
    chk("rst_h0_a_ready", 32'(har[0]), 1);
    chk("rst_h1_a_ready", 32'(har[1]), 0);
    chk("rst_h0_d_valid", 32'(hdv[0]), 0);
    chk("rst_h1_d_valid", 32'(hdv[1]), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_err", 32'(err_o), 0);
    @(negedge clk);
    rst_ni = 1;

    repeat (400) step(90, 70, 12);
    repeat (400) step(60, 50, 60);
    repeat (300) step(95, 90, 40);
    repeat (200) step(30, 40, 80);

    // Build up outstanding requests, then reset asynchronously in the middle of the cycle.
    guard = 0;
    while (q.size() < 3 && guard < 500) begin
      step(95, 90, 0);
      guard++;
    end
    chk("mid_rst_reach", 32'(q.size() >= 3), 1);
    @(negedge clk);
    #2;
    rst_ni = 0;
    model_reset();
    #1;
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_dev_a_valid", 32'(dev_a_valid), 0);
    chk("mid_rst_err", 32'(err_o), 0);
    @(negedge clk);
    rst_ni = 1;

    repeat (300) step(80, 60, 30);

    chk("saw_full", 32'(n_full > 0), 1);
    chk("saw_traffic", 32'(n_afire > 100 && n_dfire > 100), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlrot_tl_arbiter.md
# tlrot_tl_arbiter

Two-host TL-UL arbiter that shares the single 32-bit register port of the root-of-trust (RoT) between two requesters, e.g. core MMIO and the debug/SoC bridge. It sits directly in front of the RoT register interface. On the A channel it grants one host at a time in round-robin order and records which host issued each accepted request. On the D channel it steers each in-order response back to the host that issued the matching request.

## Interface
- MaxOutstanding, default 4: total accepted-but-unanswered requests allowed, summed over both hosts; legal range 1–8.
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- h0_a_valid / h1_a_valid  in  1  host A request valid.
- h0_a_ready / h1_a_ready  out  1  host A accepted.
- hN_a_bits_{opcode,param,size,source,address,mask,data}  in  3/3/2/8/32/4/32  host A payload.
- hN_d_valid  out  1  host D response valid.
- hN_d_ready  in  1  host D accept.
- hN_d_bits_{opcode,param,size,source,sink,data,denied}  out  3/3/2/8/1/32/1  host D payload; broadcast copy of the device D payload.
- dev_a_valid  out  1  request to the RoT.
- dev_a_ready  in  1  RoT accepts the request.
- dev_a_bits_*  out  payload of the granted host, same widths as host A.
- dev_d_valid  in  1  RoT response valid.
- dev_d_ready  out  1  accept the RoT response.
- dev_d_bits_*  in  RoT response payload, same widths as host D.
- busy_o  out  1  at least one request is outstanding.
- err_o  out  1  one-cycle pulse when a response arrives with no request outstanding.

## Operation
**Grant selection**
- Registered state: `prio` (host preferred on the next tie), `lock` and `lock_id` (a pending grant held stable), the order FIFO, and `count`.
- When unlocked:
  - If only one host is valid, that host is granted.
  - If both are valid, host `prio` is granted.
- When `lock`=1, `lock_id` is granted regardless of the other host.

**A channel**
- `dev_a_valid` = granted host's a_valid && !full, where full = (`count` == MaxOutstanding).
- `dev_a_bits` carry the granted host's payload unmodified. `a_source` is passed through, not remapped.
- Granted host's a_ready = dev_a_ready && !full. The non-granted host's a_ready = 0.
- A-fire (dev_a_valid && dev_a_ready):
  - push the granted id into the order FIFO;
  - `prio` <= the other host;
  - `lock` <= 0.
- If dev_a_valid=1 and dev_a_ready=0: `lock` <= 1 and `lock_id` <= the granted id. This keeps the request to the RoT stable until it is accepted.
- When full: both host a_ready=0 and dev_a_valid=0. No lock is taken.

**D channel**
- The RoT returns responses in order, so the FIFO head identifies the destination host.
- Head host's d_valid = dev_d_valid && !empty. The other host's d_valid = 0.
- dev_d_ready = head host's d_ready.
- D-fire (dev_d_valid && dev_d_ready && !empty) pops the FIFO.
- Stray response (dev_d_valid while empty):
  - dev_d_ready = 1, so the response is sunk;
  - err_o pulses one cycle later;
  - no host sees d_valid.

**Counter and status**
- `count` width = clog2(MaxOutstanding+1).
- Push and pop in the same cycle leave `count` unchanged and advance both FIFO pointers.
- FIFO pointers wrap modulo MaxOutstanding.
- busy_o = (`count` != 0).

## Timing
- A and D paths are combinational pass-through: zero added latency and no bubble between back-to-back grants.
- All state updates on the rising edge of clk_i.
- Reset values: `prio`=0, `lock`=0, `count`=0, FIFO pointers 0, err_o=0, busy_o=0.
- During reset: dev_a_valid=0 and all host d_valid=0 while host inputs are idle. Host a_ready follows dev_a_ready for host 0.
- Reset mid-transaction discards all outstanding records. The RoT is reset from the same rst_ni, so no stale responses return afterwards.
- A push while full cannot occur, because a_ready is 0 when full.
- A pop while full is allowed. It frees one slot in the next cycle, not the same cycle.

## Test plan
- **Alternation:** both hosts hold a_valid with dev_a_ready=1 for 4 cycles -> grants are h0,h1,h0,h1; FIFO order 0,1,0,1; D responses are delivered in that order to the matching hosts.
- **Grant lock:** h0 valid and dev_a_ready=0 for 3 cycles, h1 raises a_valid in cycle 1 -> dev_a_bits stay equal to h0's payload until acceptance; h1 is granted the cycle after h0's A-fire.
- **Full:** MaxOutstanding=4, 4 accepted requests with no responses -> `count`=4, both host a_ready=0, dev_a_valid=0. One D-fire -> the next cycle a_ready reasserts.
- **Same-cycle push and pop:** A-fire from h1 and D-fire to h0 in the same cycle at `count`=2 -> `count` stays 2; the next response goes to the next FIFO entry.
- **D backpressure:** head=h1 and h1_d_ready=0 while h0_d_ready=1 -> dev_d_ready=0 and h0_d_valid=0; no response is lost or misrouted.
- **Stray response and reset:** dev_d_valid=1 with `count`=0 -> dev_d_ready=1 and err_o=1 for exactly one cycle. Assert rst_ni low with `count`=3 -> busy_o=0 immediately and `count`=0.
